// File: rtl/sdhc_timeout_unit_if.sv
// Control/status bundle between the SD host core and the timeout unit.
// The host side drives the per-channel controls; the unit reports channel status.
interface sdhc_timeout_unit_if #(
    parameter int NUM_CH = 3
) ();
    logic [NUM_CH-1:0]      start_i;
    logic [NUM_CH-1:0]      stop_i;
    logic [NUM_CH-1:0]      pause_i;
    logic [NUM_CH-1:0][3:0] exp_i;
    logic [NUM_CH-1:0]      clear_i;
    logic [NUM_CH-1:0]      running_o;
    logic [NUM_CH-1:0]      timeout_o;
    logic [NUM_CH-1:0]      timeout_sticky_o;

    modport master (
        output start_i, stop_i, pause_i, exp_i, clear_i,
        input  running_o, timeout_o, timeout_sticky_o
    );

    modport slave (
        input  start_i, stop_i, pause_i, exp_i, clear_i,
        output running_o, timeout_o, timeout_sticky_o
    );
endinterface

// File: rtl/sdhc_timeout_unit.sv
// Multi-channel transaction timeout counter for the SD host controller.
// Each channel counts shared prescaler ticks up to 2**(BASE_EXP+exp) and flags expiry.
module sdhc_timeout_unit #(
    parameter int NUM_CH   = 3,
    parameter int BASE_EXP = 13,
    parameter int MAX_EXP  = 14,
    parameter int PRESCALE = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    sdhc_timeout_unit_if.slave  bus
);
    localparam int CNT_W = BASE_EXP + MAX_EXP + 1;
    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    logic [PW-1:0] r_presc;
    logic          w_tick;

    assign w_tick = (r_presc == PW'(PRESCALE - 1));

    // Free-running and shared; arming a channel never realigns it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           r_state, w_state_nx;
        logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc, w_target;
        logic [3:0]       r_thr, w_thr_nx, w_exp_clamp;
        logic             r_to, w_to_nx;
        logic             r_sticky, w_sticky_nx;
        logic             w_expire;

        assign w_exp_clamp = (bus.exp_i[g] > 4'(MAX_EXP)) ? 4'(MAX_EXP) : bus.exp_i[g];
        assign w_cnt_inc   = r_cnt + CNT_W'(1);
        assign w_target    = CNT_W'(1) << (BASE_EXP + int'(r_thr));
        assign w_expire    = (r_state == S_RUN) && w_tick && (w_cnt_inc == w_target);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_thr    <= '0;
                r_to     <= 1'b0;
                r_sticky <= 1'b0;
            end else begin
                r_state  <= w_state_nx;
                r_cnt    <= w_cnt_nx;
                r_thr    <= w_thr_nx;
                r_to     <= w_to_nx;
                r_sticky <= w_sticky_nx;
            end
        end

        // A RUN-state tick still counts on the cycle pause rises, and PAUSED
        // stays frozen on the release cycle, so the delay equals the pause length.
        always_comb begin
            w_state_nx  = r_state;
            w_cnt_nx    = r_cnt;
            w_thr_nx    = r_thr;
            w_to_nx     = 1'b0;
            w_sticky_nx = r_sticky & ~bus.clear_i[g];
            if (bus.start_i[g]) begin
                w_cnt_nx   = '0;
                w_thr_nx   = w_exp_clamp;
                w_state_nx = bus.pause_i[g] ? S_PAUSED : S_RUN;
            end else if (bus.stop_i[g]) begin
                w_state_nx = S_IDLE;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (w_tick) begin
                            w_cnt_nx = w_cnt_inc;
                        end
                        if (w_expire) begin
                            w_state_nx  = S_EXPIRED;
                            w_to_nx     = 1'b1;
                            w_sticky_nx = 1'b1;
                        end else if (bus.pause_i[g]) begin
                            w_state_nx = S_PAUSED;
                        end
                    end
                    S_PAUSED: begin
                        if (!bus.pause_i[g]) begin
                            w_state_nx = S_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        assign bus.running_o[g]        = (r_state == S_RUN) || (r_state == S_PAUSED);
        assign bus.timeout_o[g]        = r_to;
        assign bus.timeout_sticky_o[g] = r_sticky;
    end
endmodule
